// File: rtl/rgb_alarm_axil_regs.sv
// AXI4-Lite register slave for the rgb_alarm IP: four 32-bit R/W registers
// driving three PWM-modulated, optionally blinking LEDs gated by an alarm input.
module rgb_alarm_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int PWM_BITS           = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              alarm_in,
    output logic                              led_r,
    output logic                              led_g,
    output logic                              led_b
);

    typedef logic [C_S_AXI_DATA_WIDTH-1:0] word_t;

    word_t               regs_q [4];
    word_t               regs_d [4];
    logic                awready_q, awready_d;
    logic                bvalid_q, bvalid_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    word_t               rdata_q, rdata_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    word_t               bcnt_q, bcnt_d;
    logic                phase_q, phase_d;
    logic [1:0]          sync_q, sync_d;
    logic [2:0]          led_q, led_d;

    logic       wr_hs, rd_hs, half_wr, gate;
    logic [1:0] wr_idx, rd_idx;
    word_t      half_m1;

    assign wr_idx  = S_AXI_AWADDR[3:2];
    assign rd_idx  = S_AXI_ARADDR[3:2];
    assign wr_hs   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_hs   = arready_q & S_AXI_ARVALID;
    assign half_wr = wr_hs & (wr_idx == 2'd2);
    // A half period of 0 behaves as 1, so terminal count is 0 in both cases
    assign half_m1 = (regs_q[2] == '0) ? '0 : regs_q[2] - 1'b1;
    assign gate    = regs_q[0][0] & phase_q & (regs_q[0][2] ? sync_q[1] : 1'b1);

    always_comb begin
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        if (wr_hs)
            bvalid_d = 1'b1;
        else if (S_AXI_BREADY)
            bvalid_d = 1'b0;

        regs_d = regs_q;
        if (wr_hs) begin
            for (int unsigned b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
                if (S_AXI_WSTRB[b])
                    regs_d[wr_idx][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
        end

        arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (rd_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[rd_idx];
        end else if (S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end

        pwm_d  = pwm_q + 1'b1;
        sync_d = {sync_q[0], alarm_in};

        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
        if (!regs_q[0][1]) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (half_wr) begin
            bcnt_d = '0;
        end else if (bcnt_q >= half_m1) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end

        led_d[0] = gate & (pwm_q < regs_q[1][0  +: PWM_BITS]);
        led_d[1] = gate & (pwm_q < regs_q[1][8  +: PWM_BITS]);
        led_d[2] = gate & (pwm_q < regs_q[1][16 +: PWM_BITS]);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int unsigned i = 0; i < 4; i++)
                regs_q[i] <= '0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            pwm_q     <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b1;
            sync_q    <= '0;
            led_q     <= '0;
        end else begin
            regs_q    <= regs_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            pwm_q     <= pwm_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            sync_q    <= sync_d;
            led_q     <= led_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = '0;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = '0;
    assign led_r         = led_q[0];
    assign led_g         = led_q[1];
    assign led_b         = led_q[2];

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_rgb_alarm_axil_regs.sv
// Directed bench for rgb_alarm_axil_regs: cycle model of bus and LED outputs
// compared every cycle, plus hand-computed readback and LED-count expectations.
module tb_rgb_alarm_axil_regs;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [3:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [3:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        alarm_in = 1'b0;
    logic        led_r, led_g, led_b;

    always #5 ACLK = ~ACLK;

    rgb_alarm_axil_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .PWM_BITS(8)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .alarm_in(alarm_in), .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Reference model: registers as an array, PWM as cycles-since-reset mod 256
    logic [31:0]     m_regs [4];
    logic            m_awready, m_bvalid, m_arready, m_rvalid;
    logic [31:0]     m_rdata;
    logic [2:0]      m_led;
    logic [1:0]      m_al;
    bit              m_phase;
    longint unsigned m_cyc, m_bcnt;
    longint unsigned t_half, t_duty;
    bit              t_gate, t_whs, t_rhs, t_awr, t_arr;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_awready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
            m_rdata = '0; m_led = '0; m_al = '0; m_phase = 1;
            m_cyc = 0; m_bcnt = 0;
        end else begin
            t_half = (m_regs[2] == 0) ? 1 : m_regs[2];
            t_gate = m_regs[0][0] && m_phase && (!m_regs[0][2] || m_al[1]);
            for (int c = 0; c < 3; c++) begin
                t_duty   = (m_regs[1] >> (8 * c)) & 32'hFF;
                m_led[c] = t_gate && ((m_cyc % 256) < t_duty);
            end
            m_al  = {m_al[0], alarm_in};
            m_cyc = m_cyc + 1;

            t_whs = m_awready && S_AXI_AWVALID && S_AXI_WVALID;
            t_rhs = m_arready && S_AXI_ARVALID;
            t_awr = S_AXI_AWVALID && S_AXI_WVALID && !m_bvalid && !m_awready;
            t_arr = S_AXI_ARVALID && !m_rvalid && !m_arready;

            if (!m_regs[0][1]) begin
                m_bcnt = 0; m_phase = 1;
            end else if (t_whs && S_AXI_AWADDR[3:2] == 2'd2) begin
                m_bcnt = 0;
            end else if (m_bcnt + 1 >= t_half) begin
                m_bcnt = 0; m_phase = !m_phase;
            end else begin
                m_bcnt = m_bcnt + 1;
            end

            if (t_rhs) begin
                m_rdata  = m_regs[S_AXI_ARADDR[3:2]];
                m_rvalid = 1;
            end else if (S_AXI_RREADY) begin
                m_rvalid = 0;
            end

            if (t_whs) begin
                for (int b = 0; b < 4; b++)
                    if (S_AXI_WSTRB[b])
                        m_regs[S_AXI_AWADDR[3:2]][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                m_bvalid = 1;
            end else if (S_AXI_BREADY) begin
                m_bvalid = 0;
            end

            m_awready = t_awr;
            m_arready = t_arr;
        end
    end

    always @(negedge ACLK) begin
        if (chk_en)
            check("cycle_outputs",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                   S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, led_r, led_g, led_b},
                  {m_awready, m_awready, m_bvalid, 2'b00,
                   m_arready, m_rvalid, 2'b00, m_rdata, m_led[0], m_led[1], m_led[2]});
    end

    // Called just after a falling edge; returns just after a falling edge.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead,
                             input int bhold, input bit finish_resp);
        int n;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1;
        repeat (w_lead) @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_AXI_AWREADY && n < 20);
        check("aw_ready_seen", S_AXI_AWREADY, 1'b1);
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        n = 0;
        while (!S_AXI_BVALID && n < 20) begin @(negedge ACLK); n++; end
        check("bvalid_seen", S_AXI_BVALID, 1'b1);
        check("bresp", S_AXI_BRESP, 2'b00);
        if (finish_resp) begin
            repeat (bhold) begin
                @(negedge ACLK);
                check("bvalid_hold", S_AXI_BVALID, 1'b1);
            end
            S_AXI_BREADY = 1;
            @(negedge ACLK);
            S_AXI_BREADY = 0;
        end
    endtask

    task automatic axi_read(input logic [3:0] addr, input int rhold,
                            input bit finish_resp, output logic [31:0] d);
        int n;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_AXI_ARREADY && n < 20);
        check("ar_ready_seen", S_AXI_ARREADY, 1'b1);
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        check("rvalid_seen", S_AXI_RVALID, 1'b1);
        check("rresp", S_AXI_RRESP, 2'b00);
        d = S_AXI_RDATA;
        if (finish_resp) begin
            repeat (rhold) begin
                @(negedge ACLK);
                check("rdata_hold", S_AXI_RDATA, d);
            end
            S_AXI_RREADY = 1;
            @(negedge ACLK);
            S_AXI_RREADY = 0;
        end
    endtask

    logic [31:0] rd, rd2;
    logic [31:0] exp_seq [4];
    int cnt_r, cnt_g, cnt_b;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_seq[0] = 32'h1; exp_seq[1] = 32'h2; exp_seq[2] = 32'h3; exp_seq[3] = 32'h4;
        repeat (2) @(negedge ACLK);
        chk_en = 1;
        @(negedge ACLK);
        ARESETN = 1;
        check("reset_rdata", S_AXI_RDATA, 32'h0);
        check("reset_leds", {led_r, led_g, led_b}, 3'b000);
        @(negedge ACLK);

        // Sequential writes then readback
        for (int i = 0; i < 4; i++)
            axi_write(4'(i * 4), exp_seq[i], 4'hF, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), 0, 1, rd);
            check("seq_readback", rd, exp_seq[i]);
        end

        // W before AW, single byte lane, BREADY held off
        axi_write(4'hC, 32'h0, 4'hF, 0, 0, 1);
        axi_write(4'hC, 32'hAABBCCDD, 4'b0010, 3, 5, 1);
        axi_read(4'hC, 2, 1, rd);
        check("strb_readback", rd, 32'h0000CC00);

        // PWM: R duty 0x40
        axi_write(4'h4, 32'h00000040, 4'hF, 0, 0, 1);
        axi_write(4'h0, 32'h00000001, 4'hF, 0, 0, 1);
        repeat (4) @(negedge ACLK);
        cnt_r = 0; cnt_g = 0; cnt_b = 0;
        repeat (256) begin
            @(negedge ACLK);
            cnt_r += int'(led_r); cnt_g += int'(led_g); cnt_b += int'(led_b);
        end
        check("pwm_r_count", 64'(cnt_r), 64'd64);
        check("pwm_g_count", 64'(cnt_g), 64'd0);
        check("pwm_b_count", 64'(cnt_b), 64'd0);

        // Blink, half period 1000
        axi_write(4'h4, 32'h00FFFFFF, 4'hF, 0, 0, 1);
        axi_write(4'h0, 32'h00000003, 4'hF, 0, 0, 1);
        axi_write(4'h8, 32'd1000, 4'hF, 0, 0, 1);
        repeat (4) @(negedge ACLK);
        cnt_r = 0;
        repeat (2000) begin @(negedge ACLK); cnt_r += int'(led_r); end
        check_range("blink1000_on_count", cnt_r, 994, 1000);

        // Blink, half period 0 -> toggle every cycle
        axi_write(4'h8, 32'd0, 4'hF, 0, 0, 1);
        repeat (4) @(negedge ACLK);
        cnt_r = 0;
        repeat (512) begin @(negedge ACLK); cnt_r += int'(led_r); end
        check_range("blink0_on_count", cnt_r, 254, 256);

        // Alarm mode: 10-cycle pulse
        axi_write(4'h0, 32'h00000005, 4'hF, 0, 0, 1);
        repeat (6) @(negedge ACLK);
        check("alarm_idle_off", led_r, 1'b0);
        alarm_in = 1;
        cnt_r = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge ACLK);
            if (k == 2) check("alarm_not_early", led_r, 1'b0);
            if (k >= 3 && k <= 12) cnt_r += int'(led_r);
            if (k == 13) check("alarm_off_after", led_r, 1'b0);
            if (k == 10) alarm_in = 0;
        end
        check_range("alarm_on_count", cnt_r, 9, 10);

        // Same-cycle read/write returns old value; one cycle later returns new
        axi_write(4'h4, 32'h11223344, 4'hF, 0, 0, 1);
        fork
            axi_write(4'h4, 32'h55667788, 4'hF, 0, 0, 1);
            axi_read(4'h4, 0, 1, rd);
        join
        check("rw_same_cycle_old", rd, 32'h11223344);
        fork
            axi_write(4'h4, 32'h99AABBCC, 4'hF, 0, 0, 1);
            begin @(negedge ACLK); axi_read(4'h4, 0, 1, rd2); end
        join
        check("rw_next_cycle_new", rd2, 32'h99AABBCC);

        // Reset while BVALID is high
        axi_write(4'h0, 32'h00000007, 4'hF, 0, 0, 0);
        #2 ARESETN = 0;
        #1 check("rst_during_b",
                 {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
                  S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, led_r, led_g, led_b}, 64'h0);
        @(negedge ACLK);
        ARESETN = 1;
        @(negedge ACLK);
        check("no_b_after_reset", S_AXI_BVALID, 1'b0);

        // Reset while RVALID is high
        axi_write(4'h4, 32'h00ABCDEF, 4'hF, 0, 0, 1);
        axi_read(4'h4, 0, 0, rd);
        check("pre_reset_read", rd, 32'h00ABCDEF);
        #2 ARESETN = 0;
        #1 check("rst_during_r",
                 {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
                  S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, led_r, led_g, led_b}, 64'h0);
        @(negedge ACLK);
        ARESETN = 1;
        @(negedge ACLK);
        check("no_r_after_reset", S_AXI_RVALID, 1'b0);
        axi_read(4'h0, 0, 1, rd);
        check("ctrl_after_reset", rd, 32'h0);
        axi_read(4'h4, 0, 1, rd);
        check("color_after_reset", rd, 32'h0);

        repeat (3) @(negedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
